// File: rtl/correlator_pkg.sv
// Shared types and helpers for the correlator transmit path.
package correlator_pkg;

    localparam int         FOOTER_BITS = 64;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic [2:0] {IDLE, SNAP, HDR, PAY, FTR, EOL, DONE} state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'd0, nib};
        else
            return 8'h37 + {4'd0, nib};
    endfunction

endpackage

// File: rtl/byte_stream_reg.sv
// One-entry valid/ready output register; holds a byte stable until it is taken.
module byte_stream_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       ready,
    output logic [7:0] data,
    output logic       valid,
    output logic       can_load
);

    // Empty, or the held byte leaves this cycle.
    assign can_load = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/correlation_packetizer.sv
// Snapshots the correlator accumulators on a trigger and streams a framed
// packet (header, payload, count/checksum footer) as raw bytes or ASCII hex.
//
// state | meaning
// IDLE  | waiting for trigger while enabled
// SNAP  | latch header/pulses, pulse clear_acc, compute checksum
// HDR   | header unit in flight
// PAY   | payload unit in flight
// FTR   | footer unit in flight
// EOL   | carriage return in flight (ASCII only)
// DONE  | one-cycle done pulse, packet counter advances
module correlation_packetizer
    import correlator_pkg::*;
#(
    parameter int PAYLOAD_BITS = 48,
    parameter int HEADER_BITS  = 64,
    parameter int BINARY       = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    trigger,
    input  logic [PAYLOAD_BITS-1:0] pulses,
    input  logic [HEADER_BITS-1:0]  header,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    clear_acc,
    output logic                    busy,
    output logic                    done
);

    localparam int FRAME_BITS = HEADER_BITS + PAYLOAD_BITS + FOOTER_BITS;
    localparam int BIN_BYTES  = FRAME_BITS / 8;
    localparam int UNIT_BITS  = (BINARY != 0) ? 8 : 4;
    localparam int UNITS      = (BINARY != 0) ? BIN_BYTES : 2 * BIN_BYTES + 1;
    localparam int HDR_END    = HEADER_BITS / UNIT_BITS;
    localparam int PAY_END    = (HEADER_BITS + PAYLOAD_BITS) / UNIT_BITS;
    localparam int FTR_END    = FRAME_BITS / UNIT_BITS;
    localparam int IDX_W      = $clog2(UNITS + 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [HEADER_BITS-1:0]  header_q;
    logic [PAYLOAD_BITS-1:0] payload_q;
    logic [31:0]             pkt_count;
    logic [31:0]             checksum;
    logic [31:0]             checksum_next;
    logic [FRAME_BITS-1:0]   frame;
    logic [7:0]              unit_data;
    logic                    load;
    logic                    can_load;
    int                      pos;

    function automatic state_t section_of(input int u);
        if (u < HDR_END) return HDR;
        if (u < PAY_END) return PAY;
        if (u < FTR_END) return FTR;
        return EOL;
    endfunction

    always_comb begin
        checksum_next = '0;
        for (int i = 0; i < PAYLOAD_BITS / 8; i++)
            checksum_next = checksum_next + 32'(pulses[i*8 +: 8]);
    end

    // During SNAP the registers are not yet loaded, so the first unit comes
    // straight from the inputs to keep the header on the wire one cycle later.
    always_comb begin
        if (state == SNAP)
            frame = {header, pulses, pkt_count, checksum_next};
        else
            frame = {header_q, payload_q, pkt_count, checksum};
    end

    always_comb begin
        pos       = (int'(idx) < FTR_END) ? int'(idx) : 0;
        unit_data = ASCII_CR;
        if (BINARY != 0)
            unit_data = frame[FRAME_BITS - 8 - 8*pos +: 8];
        else if (int'(idx) < FTR_END)
            unit_data = nibble_to_ascii(frame[FRAME_BITS - 4 - 4*pos +: 4]);
    end

    assign load = can_load &&
                  (state == SNAP ||
                   ((state == HDR || state == PAY || state == FTR || state == EOL) &&
                    int'(idx) < UNITS));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            header_q  <= '0;
            payload_q <= '0;
            pkt_count <= '0;
            checksum  <= '0;
            clear_acc <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            clear_acc <= 1'b0;
            done      <= 1'b0;
            if (load)
                idx <= idx + IDX_W'(1);
            case (state)
                IDLE: begin
                    if (trigger && enable) begin
                        state     <= SNAP;
                        clear_acc <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SNAP: begin
                    header_q  <= header;
                    payload_q <= pulses;
                    checksum  <= checksum_next;
                    state     <= HDR;
                end
                HDR, PAY, FTR, EOL: begin
                    if (load) begin
                        state <= section_of(int'(idx));
                    end else if (int'(idx) == UNITS && tx_valid && tx_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    pkt_count <= pkt_count + 32'd1;
                    idx       <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    byte_stream_reg u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (unit_data),
        .ready     (tx_ready),
        .data      (tx_data),
        .valid     (tx_valid),
        .can_load  (can_load)
    );

endmodule

// File: tb/tb_correlation_packetizer.sv
// Bench for correlation_packetizer: binary and ASCII instances side by side,
// checked every cycle against a frame-level model plus literal frames.
module tb_correlation_packetizer;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        enable   = 1'b0;
    logic        trigger  = 1'b0;
    logic        tx_ready = 1'b1;
    logic [15:0] pulses   = '0;
    logic [63:0] header   = '0;

    logic [7:0] txd [2];
    logic       txv [2];
    logic       clr [2];
    logic       bsy [2];
    logic       dn  [2];

    int checks = 0, passes = 0, cyc = 0;
    int phase [2];
    int mcount [2];
    int trig_cyc = 0, clr_cyc = -1, done_cyc = -1;
    logic mon_en = 1'b0;
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] cap0 [$];
    logic [7:0] cap1 [$];
    string hex_digits = "0123456789ABCDEF";
    string asc_lit    = "0123456789ABCDEFA53C00000000000000E1";
    string cnt1_lit   = "00000001";
    logic [7:0] bin_lit [18] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                                 8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h00, 8'h00, 8'h00, 8'hE1};

    always #5 clk = ~clk;

    correlation_packetizer #(.PAYLOAD_BITS(16), .HEADER_BITS(64), .BINARY(1)) dut_bin (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .pulses(pulses), .header(header),
        .tx_data(txd[0]), .tx_valid(txv[0]), .tx_ready(tx_ready),
        .clear_acc(clr[0]), .busy(bsy[0]), .done(dn[0]));

    correlation_packetizer #(.PAYLOAD_BITS(16), .HEADER_BITS(64), .BINARY(0)) dut_asc (
        .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
        .pulses(pulses), .header(header),
        .tx_data(txd[1]), .tx_valid(txv[1]), .tx_ready(tx_ready),
        .clear_acc(clr[1]), .busy(bsy[1]), .done(dn[1]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", name, k, act, exp, cyc);
    endtask

    // Whole frame from the rules: header, payload, {count, byte-sum}, MSB first.
    task automatic build_frame(input int k);
        logic [7:0]  b [$];
        logic [31:0] sum;
        logic [31:0] cnt;
        cnt = mcount[k];
        for (int i = 0; i < 8; i++) b.push_back(header[63-8*i -: 8]);
        b.push_back(pulses[15:8]);
        b.push_back(pulses[7:0]);
        sum = 32'(pulses[15:8]) + 32'(pulses[7:0]);
        for (int i = 0; i < 4; i++) b.push_back(cnt[31-8*i -: 8]);
        for (int i = 0; i < 4; i++) b.push_back(sum[31-8*i -: 8]);
        if (k == 0) begin
            foreach (b[i]) q0.push_back(b[i]);
        end else begin
            foreach (b[i]) begin
                q1.push_back(hex_digits[int'(b[i][7:4])]);
                q1.push_back(hex_digits[int'(b[i][3:0])]);
            end
            q1.push_back(8'h0D);
        end
    endtask

    task automatic step(input int k);
        logic [7:0] front;
        int qs;
        qs    = (k == 0) ? q0.size() : q1.size();
        front = '0;
        if (qs > 0) front = (k == 0) ? q0[0] : q1[0];
        chk("clear_acc", k, 32'(clr[k]), 32'(phase[k] == 1));
        chk("busy",      k, 32'(bsy[k]), 32'(phase[k] == 1 || phase[k] == 2));
        chk("done",      k, 32'(dn[k]),  32'(phase[k] == 3));
        chk("tx_valid",  k, 32'(txv[k]), 32'(phase[k] == 2));
        if (phase[k] == 2) chk("tx_data", k, 32'(txd[k]), 32'(front));
        if (k == 0) begin
            if (clr[0] && clr_cyc < 0) clr_cyc = cyc;
            if (dn[0] && done_cyc < 0) done_cyc = cyc;
        end
        if (reset) begin
            phase[k]  = 0;
            mcount[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
        end else begin
            case (phase[k])
                0: if (trigger && enable) begin
                       phase[k] = 1;
                       if (k == 0) trig_cyc = cyc;
                   end
                1: begin build_frame(k); phase[k] = 2; end
                2: if (tx_ready && qs > 0) begin
                       if (k == 0) begin cap0.push_back(txd[0]); void'(q0.pop_front()); end
                       else        begin cap1.push_back(txd[1]); void'(q1.pop_front()); end
                       if (qs == 1) phase[k] = 3;
                   end
                3: begin phase[k] = 0; mcount[k]++; end
                default: phase[k] = 0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (mon_en) for (int k = 0; k < 2; k++) step(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input bit rnd);
        int n = 0;
        while (!(phase[0] == 0 && phase[1] == 0) && n < limit) begin
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        tx_ready = 1'b1;
        chk("idle_timeout", 0, 32'(n < limit), 32'd1);
        tick();
    endtask

    task automatic clear_caps();
        cap0.delete();
        cap1.delete();
    endtask

    initial begin
        phase  = '{0, 0};
        mcount = '{0, 0};
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        reset  = 1'b0;
        enable = 1'b1;
        header = 64'h0123456789ABCDEF;
        pulses = 16'hA53C;
        tick();

        // First packet, both encodings, literal frames and timing.
        clear_caps();
        clr_cyc = -1; done_cyc = -1;
        pulse_trigger();
        wait_idle(200, 1'b0);
        chk("clear_acc_cycle", 0, 32'(clr_cyc - trig_cyc), 32'd1);
        chk("done_cycle", 0, 32'(done_cyc - trig_cyc), 32'd20);
        chk("bin_len", 0, 32'(cap0.size()), 32'd18);
        for (int i = 0; i < 18 && i < cap0.size(); i++) chk("bin_byte", i, 32'(cap0[i]), 32'(bin_lit[i]));
        chk("asc_len", 1, 32'(cap1.size()), 32'd37);
        for (int i = 0; i < 36 && i < cap1.size(); i++) chk("asc_char", i, 32'(cap1[i]), 32'(asc_lit[i]));
        if (cap1.size() == 37) chk("asc_cr", 1, 32'(cap1[36]), 32'h0D);

        // Second packet: pulses change after SNAP, stray trigger while busy, enable drops.
        clear_caps();
        pulse_trigger();
        tick();
        pulses = 16'h0000;
        repeat (3) tick();
        pulse_trigger();
        enable = 1'b0;
        wait_idle(200, 1'b0);
        enable = 1'b1;
        if (cap0.size() == 18) begin
            chk("snap_payload", 0, 32'(cap0[8]), 32'hA5);
            chk("bin_count1", 0, 32'(cap0[13]), 32'h01);
        end else chk("bin_len2", 0, 32'(cap0.size()), 32'd18);
        if (cap1.size() == 37)
            for (int i = 0; i < 8; i++) chk("asc_count1", i, 32'(cap1[20+i]), 32'(cnt1_lit[i]));
        else chk("asc_len2", 1, 32'(cap1.size()), 32'd37);

        // Trigger while idle with enable low must do nothing.
        enable = 1'b0;
        pulse_trigger();
        repeat (5) tick();
        enable = 1'b1;

        // Reset mid-packet after the 5th accepted byte.
        pulses = 16'hA53C;
        clear_caps();
        pulse_trigger();
        begin
            int n = 0;
            while (cap0.size() < 5 && n < 50) begin tick(); n++; end
            chk("fifth_byte_timeout", 0, 32'(n < 50), 32'd1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset_tx_valid", 0, 32'(txv[0]), 32'd0);
        chk("reset_busy", 0, 32'(bsy[0]), 32'd0);
        chk("reset_tx_valid", 1, 32'(txv[1]), 32'd0);
        chk("reset_busy", 1, 32'(bsy[1]), 32'd0);
        tick();

        // Restart with a randomly stalling receiver: same literal frame, count back at 0.
        clear_caps();
        pulse_trigger();
        wait_idle(600, 1'b1);
        chk("stall_len", 0, 32'(cap0.size()), 32'd18);
        for (int i = 0; i < 18 && i < cap0.size(); i++) chk("stall_byte", i, 32'(cap0[i]), 32'(bin_lit[i]));

        // All-ones payload: checksum 0x1FE.
        pulses = 16'hFFFF;
        clear_caps();
        pulse_trigger();
        wait_idle(200, 1'b0);
        if (cap0.size() == 18) begin
            chk("cksum_b3", 0, 32'(cap0[14]), 32'h00);
            chk("cksum_b2", 0, 32'(cap0[15]), 32'h00);
            chk("cksum_b1", 0, 32'(cap0[16]), 32'h01);
            chk("cksum_b0", 0, 32'(cap0[17]), 32'hFE);
        end else chk("cksum_len", 0, 32'(cap0.size()), 32'd18);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
